// File: rtl/instr_trace_capture.sv
// Trigger-armed instruction trace FIFO. It sits beside the core and samples qualified
// instruction words. A host drains it through a show-ahead valid/ready read port.
module instr_trace_capture #(
  parameter int DEPTH     = 16,
  parameter int FULL_STOP = 0,
  parameter int DROP_W    = 16,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  input  logic              arm,
  input  logic              stop,
  input  logic [31:0]       trig_instr,
  input  logic [31:0]       trig_mask,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic [CW-1:0]     count,
  output logic [1:0]        state,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic                overflow_q;
  logic [DROP_W-1:0]   drop_cnt_q;
  logic [31:0]         mem_q [DEPTH];

  logic match, pop, wr_req, push, drop, clr;

  assign match = instr_valid && (((instruction ^ trig_instr) & trig_mask) == 32'd0);
  assign pop   = (count_q != '0) && rd_ready;

  always_comb begin
    state_d = state_q;
    wr_req  = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE, DONE: if (arm && !stop) begin
        state_d = ARMED;
        clr     = 1'b1;
      end
      ARMED: begin
        if (stop) state_d = IDLE;
        else if (match) begin
          state_d = CAPTURE;
          wr_req  = 1'b1;
        end
      end
      CAPTURE: begin
        if (stop) state_d = DONE;
        else      wr_req  = instr_valid;
      end
      default: state_d = IDLE;
    endcase

    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    push = wr_req && ((count_q != FULL) || pop);
    drop = wr_req && !push;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if ((FULL_STOP != 0) && (state_d == CAPTURE) && (count_d == FULL)) state_d = DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (clr) begin
        overflow_q <= 1'b0;
        drop_cnt_q <= '0;
      end else if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
      end
    end
  end

  // Storage needs no reset; an empty FIFO forces rd_data to zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= instruction;
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : 32'd0;
  assign count    = count_q;
  assign state    = state_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_instr_trace_capture.sv
// Directed bench for instr_trace_capture: a vector table for the trigger/read flow and
// hand sequences for reset, overflow, full-stop and full-FIFO streaming.
module tb_instr_trace_capture;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic        instr_valid = 1'b0, arm = 1'b0, stop = 1'b0, rd_ready = 1'b0;
  logic [31:0] trig_instr = 32'h13, trig_mask = 32'h7F;

  logic        rv0, rv1, ov0, ov1;
  logic [31:0] rd0, rd1;
  logic [4:0]  cnt0, cnt1;
  logic [1:0]  st0, st1;
  logic [15:0] dc0, dc1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  instr_trace_capture #(.DEPTH(16), .FULL_STOP(0), .DROP_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .instr_valid(instr_valid),
    .arm(arm), .stop(stop), .trig_instr(trig_instr), .trig_mask(trig_mask),
    .rd_ready(rd_ready), .rd_valid(rv0), .rd_data(rd0), .count(cnt0), .state(st0),
    .overflow(ov0), .drop_cnt(dc0));

  instr_trace_capture #(.DEPTH(16), .FULL_STOP(1), .DROP_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .instr_valid(instr_valid),
    .arm(arm), .stop(stop), .trig_instr(trig_instr), .trig_mask(trig_mask),
    .rd_ready(rd_ready), .rd_valid(rv1), .rd_data(rd1), .count(cnt1), .state(st1),
    .overflow(ov1), .drop_cnt(dc1));

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic        a, s, r;
    logic        chk_rd;
    logic        rv;
    logic [31:0] rd;
    logic [4:0]  cnt;
    logic [1:0]  st;
    logic        ov;
    logic [15:0] dc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [31:0] ins, logic a, logic s, logic r,
                              logic chk_rd, logic rv, logic [31:0] rd, logic [4:0] cnt,
                              logic [1:0] st);
    vec_t t;
    t.v = v; t.ins = ins; t.a = a; t.s = s; t.r = r;
    t.chk_rd = chk_rd; t.rv = rv; t.rd = rd; t.cnt = cnt; t.st = st;
    t.ov = 1'b0; t.dc = 16'd0;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    instr_valid = 1'b0; instruction = '0; arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    idle_inputs();
    #12;
    chk("rst_state0", 32'(st0), 32'd0);
    chk("rst_count0", 32'(cnt0), 32'd0);
    chk("rst_rvalid0", 32'(rv0), 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_ovf0", 32'(ov0), 32'd0);
    chk("rst_drop0", 32'(dc0), 32'd0);
    chk("rst_state1", 32'(st1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Mid-capture reset with 5 entries clears the FIFO without waiting for an edge
    trig_mask = 32'd0;
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      instr_valid = 1'b1; instruction = 32'h500 + 32'(i); step();
    end
    idle_inputs();
    chk("mid_cnt5", 32'(cnt0), 32'd5);
    chk("mid_state", 32'(st0), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(cnt0), 32'd0);
    chk("mid_rst_rv", 32'(rv0), 32'd0);
    chk("mid_rst_st", 32'(st0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Trigger / read / stop table (opcode match on OP-IMM)
    trig_instr = 32'h13; trig_mask = 32'h7F;
    tbl.push_back(mk(0, 32'h0,        1, 0, 0, 1, 0, 32'h0,        5'd0, 2'd1));
    tbl.push_back(mk(1, 32'h00000033, 0, 0, 0, 1, 0, 32'h0,        5'd0, 2'd1));
    tbl.push_back(mk(1, 32'h00500093, 0, 0, 0, 0, 0, 32'h0,        5'd1, 2'd2));
    tbl.push_back(mk(1, 32'h00A00113, 0, 0, 0, 1, 1, 32'h00500093, 5'd2, 2'd2));
    tbl.push_back(mk(0, 32'h0,        0, 0, 1, 1, 1, 32'h00A00113, 5'd1, 2'd2));
    tbl.push_back(mk(0, 32'h0,        0, 0, 1, 1, 0, 32'h0,        5'd0, 2'd2));
    tbl.push_back(mk(0, 32'h0,        0, 1, 0, 1, 0, 32'h0,        5'd0, 2'd3));
    tbl.push_back(mk(0, 32'h0,        0, 1, 0, 1, 0, 32'h0,        5'd0, 2'd3));
    tbl.push_back(mk(0, 32'h0,        1, 0, 0, 1, 0, 32'h0,        5'd0, 2'd1));
    tbl.push_back(mk(0, 32'h0,        1, 1, 0, 1, 0, 32'h0,        5'd0, 2'd0));
    tbl.push_back(mk(1, 32'h00000013, 0, 0, 0, 1, 0, 32'h0,        5'd0, 2'd0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 0, 1, 0, 32'h0,        5'd0, 2'd1));
    tbl.push_back(mk(1, 32'h00100013, 0, 0, 0, 0, 0, 32'h0,        5'd1, 2'd2));
    tbl.push_back(mk(1, 32'h00200013, 0, 0, 1, 1, 1, 32'h00200013, 5'd1, 2'd2));
    tbl.push_back(mk(1, 32'h00300013, 0, 1, 0, 1, 1, 32'h00200013, 5'd1, 2'd3));
    tbl.push_back(mk(0, 32'h0,        0, 0, 1, 1, 0, 32'h0,        5'd0, 2'd3));

    foreach (tbl[k]) begin
      instr_valid = tbl[k].v; instruction = tbl[k].ins;
      arm = tbl[k].a; stop = tbl[k].s; rd_ready = tbl[k].r;
      step();
      chk($sformatf("v%0d_state", k), 32'(st0), 32'(tbl[k].st));
      chk($sformatf("v%0d_count", k), 32'(cnt0), 32'(tbl[k].cnt));
      chk($sformatf("v%0d_ovf", k), 32'(ov0), 32'(tbl[k].ov));
      chk($sformatf("v%0d_drop", k), 32'(dc0), 32'(tbl[k].dc));
      if (tbl[k].chk_rd) begin
        chk($sformatf("v%0d_rvalid", k), 32'(rv0), 32'(tbl[k].rv));
        chk($sformatf("v%0d_rdata", k), rd0, tbl[k].rd);
      end
    end
    idle_inputs();

    // Overflow (u0) and full-stop (u1) with 20 words, no reads
    do_reset();
    trig_mask = 32'd0;
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      instr_valid = 1'b1; instruction = 32'h1000 + 32'(i);
      step();
      if (i == 14) chk("fs_state_before_full", 32'(st1), 32'd2);
      if (i == 15) begin
        chk("fs_state_at_full", 32'(st1), 32'd3);
        chk("fs_count_at_full", 32'(cnt1), 32'd16);
      end
    end
    idle_inputs();
    chk("ovf_count", 32'(cnt0), 32'd16);
    chk("ovf_flag", 32'(ov0), 32'd1);
    chk("ovf_drop", 32'(dc0), 32'd4);
    chk("ovf_state", 32'(st0), 32'd2);
    chk("fs_count", 32'(cnt1), 32'd16);
    chk("fs_drop", 32'(dc1), 32'd0);
    chk("fs_ovf", 32'(ov1), 32'd0);
    chk("fs_state", 32'(st1), 32'd3);

    // Re-arm: u1 keeps data; arm is ignored by u0 while capturing
    arm = 1'b1; step(); arm = 1'b0;
    chk("rearm_state1", 32'(st1), 32'd1);
    chk("rearm_count1", 32'(cnt1), 32'd16);
    chk("rearm_head1", rd1, 32'h1000);
    chk("rearm_state0", 32'(st0), 32'd2);
    chk("rearm_drop0", 32'(dc0), 32'd4);

    // Full FIFO with read and write every cycle
    for (int i = 0; i < 8; i++) begin
      instr_valid = 1'b1; instruction = 32'h2000 + 32'(i); rd_ready = 1'b1;
      step();
      chk($sformatf("stream%0d_count", i), 32'(cnt0), 32'd16);
    end
    idle_inputs();
    chk("stream_drop", 32'(dc0), 32'd4);

    // Drain u0 and confirm order
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), rd0, (i < 8) ? (32'h1008 + 32'(i)) : (32'h2000 + 32'(i - 8)));
      step();
    end
    rd_ready = 1'b0;
    chk("drain_count", 32'(cnt0), 32'd0);
    chk("drain_rvalid", 32'(rv0), 32'd0);
    chk("drain_rdata", rd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
